display_scan_controller: RTL



---
 rtl/display_scan_controller_pkg.sv | 22 ++
 rtl/display_scan_controller_timebase.sv | 47 ++++
 rtl/display_scan_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared definitions for the display scan controller: state encoding,
// anode constants and the digit-to-anode one-hot mapping.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  ANODE_OFF  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    ON
  } scan_state_e;

  // Active-low one-hot anode pattern for a digit index (0 = rightmost).
  function automatic logic [3:0] digit_anode(input logic [1:0] sel);
    logic [3:0] a;
    a      = ANODE_OFF;
    a[sel] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/display_scan_controller_timebase.sv
// Slot timebase: counts 0..SLOT_CYCLES-1 and flags the last cycle of the
// slot (wrap) and the last cycle of the blanking gap (blank end).
module scan_timebase
  import display_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 25000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned CNT_W        = $clog2(SLOT_CYCLES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             run_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             blank_end_o
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: synchronous clear has priority, otherwise step and wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Slot counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign wrap_o      = (cnt_q == LAST_CNT);
  assign blank_end_o = (cnt_q == BLANK_END);

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexing scan controller for a 4-digit common-anode 7-segment
// display. Each digit slot starts with a blanking gap (all anodes off),
// then drives the digit's active-low anode. bcd_in/digit_en are captured
// only at frame start so a frame never tears.
// Optional feature macro: DISPLAY_DIM_EN adds a brightness port and PWM
// dimming within the ON phase.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES  = 25000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  digit_en,
`ifdef DISPLAY_DIM_EN
  input  logic [3:0]  brightness,
`endif
  output logic [1:0]  digit_sel,
  output logic [3:0]  digit_value,
  output logic [3:0]  anode,
  output logic        frame_start
);

  localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);

  scan_state_e state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  value_q, value_d;
  logic [3:0]  anode_q, anode_d;
  logic        fs_q, fs_d;
  logic [15:0] bcd_snap_q, bcd_snap_d;
  logic [3:0]  en_snap_q, en_snap_d;
`ifdef DISPLAY_DIM_EN
  logic [3:0]  pwm_q, pwm_d;
  logic [3:0]  bright_q, bright_d;
`endif

  logic [CNT_W-1:0] slot_cnt;
  logic             slot_wrap;
  logic             blank_end;
  logic             tb_clear;
  logic             anode_on;

  // Counter is parked at 0 while idle or disabled so each start is slot-aligned.
  assign tb_clear = !enable || (state_q == IDLE);

  scan_timebase #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timebase (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .clear_i    (tb_clear),
    .run_i      (1'b1),
    .cnt_o      (slot_cnt),
    .wrap_o     (slot_wrap),
    .blank_end_o(blank_end)
  );

  // Next state, digit stepping, snapshots, and registered output values.
  // Outputs are computed from the next-state values so that the registered
  // anode/digit_value always match the registered state and digit_sel.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    fs_d       = 1'b0;
    bcd_snap_d = bcd_snap_q;
    en_snap_d  = en_snap_q;
`ifdef DISPLAY_DIM_EN
    bright_d   = bright_q;
`endif

    if (!enable) begin
      state_d = IDLE;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = BLANK;
          sel_d      = '0;
          fs_d       = 1'b1;
          bcd_snap_d = bcd_in;
          en_snap_d  = digit_en;
`ifdef DISPLAY_DIM_EN
          bright_d   = brightness;
`endif
        end
        BLANK: begin
          if (blank_end) begin
            state_d = ON;
          end
        end
        ON: begin
          if (slot_wrap) begin
            state_d = BLANK;
            sel_d   = sel_q + 2'd1;
            if (sel_q == 2'd3) begin
              fs_d       = 1'b1;
              bcd_snap_d = bcd_in;
              en_snap_d  = digit_en;
`ifdef DISPLAY_DIM_EN
              bright_d   = brightness;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

`ifdef DISPLAY_DIM_EN
    pwm_d = '0;
    if (state_d == ON && state_q == ON) begin
      pwm_d = pwm_q + 4'd1;
    end
    anode_on = (pwm_d <= bright_d);
`else
    anode_on = 1'b1;
`endif

    value_d = bcd_snap_d[{sel_d, 2'b00} +: 4];
    anode_d = ANODE_OFF;
    if (state_d == ON && en_snap_d[sel_d] && anode_on) begin
      anode_d = digit_anode(sel_d);
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      value_q    <= '0;
      anode_q    <= ANODE_OFF;
      fs_q       <= 1'b0;
      bcd_snap_q <= '0;
      en_snap_q  <= '0;
`ifdef DISPLAY_DIM_EN
      pwm_q      <= '0;
      bright_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      value_q    <= value_d;
      anode_q    <= anode_d;
      fs_q       <= fs_d;
      bcd_snap_q <= bcd_snap_d;
      en_snap_q  <= en_snap_d;
`ifdef DISPLAY_DIM_EN
      pwm_q      <= pwm_d;
      bright_q   <= bright_d;
`endif
    end
  end

  assign digit_sel   = sel_q;
  assign digit_value = value_q;
  assign anode       = anode_q;
  assign frame_start = fs_q;

endmodule
